// File: rtl/ppu_reg_responder.sv
// ppu_reg_responder
//   PPU-side responder for the CPU register window (PPUCTRL..PPUDATA, OAMDMA).
//   Holds control/mask/status state, the scroll/VRAM address registers
//   (v, t, fine-x, write toggle w), sequences VRAM/OAM data accesses and
//   generates NMI.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   clock_en                  CPU-cycle enable (never high two clocks running)
//   reg_sel/en/rw/data_wr     CPU access; accepted on edges with reg_en & clock_en
//   reg_data_rd               registered read data
//   vblank_set/vblank_clr     status timing pulses from the render core
//   sprite0_hit_set           sets status bit 6
//   overflow_set              sets status bit 5
//   ppuctrl, ppumask          current control / mask registers
//   vram_v, vram_t, fine_x    scroll / address state
//   vram_rd/wr/addr/wdata     VRAM strobes (combinational, during the accepting cycle)
//   vram_rdata                VRAM data, valid one clock after vram_rd
//   oam_addr/we/wdata         OAM port (write strobe during the accepting cycle)
//   oam_rdata                 OAM data at oam_addr (combinational)
//   dma_start, dma_page       OAMDMA request (registered pulse + page)
//   nmi                       NMI request level (registered)

package ppu_reg_responder_pkg;
  typedef enum logic [3:0] {
    SEL_CTRL    = 4'd0,
    SEL_MASK    = 4'd1,
    SEL_STATUS  = 4'd2,
    SEL_OAMADDR = 4'd3,
    SEL_OAMDATA = 4'd4,
    SEL_SCROLL  = 4'd5,
    SEL_ADDR    = 4'd6,
    SEL_DATA    = 4'd7,
    SEL_OAMDMA  = 4'd8
  } reg_t;
endpackage

module ppu_reg_responder
  import ppu_reg_responder_pkg::*;
#(
  parameter logic [5:0] PAL_HI = 6'h3F
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_en,
  input  reg_t        reg_sel,
  input  logic        reg_en,
  input  logic        reg_rw,
  input  logic [7:0]  reg_data_wr,
  output logic [7:0]  reg_data_rd,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        sprite0_hit_set,
  input  logic        overflow_set,
  output logic [7:0]  ppuctrl,
  output logic [7:0]  ppumask,
  output logic [14:0] vram_v,
  output logic [14:0] vram_t,
  output logic [2:0]  fine_x,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic        dma_start,
  output logic [7:0]  dma_page,
  output logic        nmi
);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t      r_state, w_state_nxt;

  logic [7:0]  r_ctrl, r_mask, r_latch, r_buf, r_rd, r_oam_addr, r_dma_page;
  logic [14:0] r_v, r_t;
  logic [2:0]  r_x;
  logic        r_w, r_vblank, r_s0, r_ovf, r_nmi, r_dma_start, r_pal;

  logic        w_acc, w_wr, w_rd, w_status_rd, w_data_rd, w_pal;
  logic        w_buf_load, w_pal_load;
  logic [14:0] w_inc;
  logic [7:0]  w_rd_data;

  // Gating with reset_n keeps the combinational strobes quiet while reset is held.
  assign w_acc       = reg_en & clock_en & reset_n;
  assign w_wr        = w_acc & reg_rw;
  assign w_rd        = w_acc & ~reg_rw;
  assign w_status_rd = w_rd & (reg_sel == SEL_STATUS);
  assign w_data_rd   = w_rd & (reg_sel == SEL_DATA);
  assign w_pal       = (r_v[13:8] == PAL_HI);
  assign w_inc       = r_ctrl[2] ? 15'd32 : 15'd1;

  // Read mux: registers without bits of their own fall back to the open-bus latch.
  always_comb begin
    w_rd_data = r_latch;
    case (reg_sel)
      SEL_STATUS:  w_rd_data = {r_vblank, r_s0, r_ovf, r_latch[4:0]};
      SEL_OAMDATA: w_rd_data = oam_rdata;
      SEL_DATA:    w_rd_data = r_buf;
      default:     w_rd_data = r_latch;
    endcase
  end

  // PPUDATA read FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // PPUDATA read FSM: next state
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:    w_state_nxt = w_data_rd ? S_RD_WAIT : S_IDLE;
      S_RD_WAIT: w_state_nxt = w_data_rd ? S_RD_WAIT : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // PPUDATA read FSM: outputs
  always_comb begin
    w_buf_load = 1'b0;
    w_pal_load = 1'b0;
    if (r_state == S_RD_WAIT) begin
      w_buf_load = 1'b1;
      w_pal_load = r_pal;
    end
  end

  // Register file, address state and read data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl      <= '0;
      r_mask      <= '0;
      r_latch     <= '0;
      r_buf       <= '0;
      r_rd        <= '0;
      r_oam_addr  <= '0;
      r_dma_page  <= '0;
      r_dma_start <= 1'b0;
      r_v         <= '0;
      r_t         <= '0;
      r_x         <= '0;
      r_w         <= 1'b0;
      r_pal       <= 1'b0;
    end else begin
      r_dma_start <= w_wr & (reg_sel == SEL_OAMDMA);

      if (w_buf_load) r_buf <= vram_rdata;

      // Palette reads skip the buffer and load one clock later from VRAM.
      if (w_rd && !(w_data_rd && w_pal)) r_rd <= w_rd_data;
      else if (w_pal_load)               r_rd <= {r_latch[7:6], vram_rdata[5:0]};

      if (w_data_rd) r_pal <= w_pal;

      if (w_wr) begin
        r_latch <= reg_data_wr;
        case (reg_sel)
          SEL_CTRL: begin
            r_ctrl      <= reg_data_wr;
            r_t[11:10]  <= reg_data_wr[1:0];
          end
          SEL_MASK:    r_mask <= reg_data_wr;
          SEL_OAMADDR: r_oam_addr <= reg_data_wr;
          SEL_OAMDATA: r_oam_addr <= r_oam_addr + 8'd1;
          SEL_SCROLL: begin
            if (!r_w) begin
              r_t[4:0] <= reg_data_wr[7:3];
              r_x      <= reg_data_wr[2:0];
            end else begin
              r_t[14:12] <= reg_data_wr[2:0];
              r_t[9:5]   <= reg_data_wr[7:3];
            end
            r_w <= ~r_w;
          end
          SEL_ADDR: begin
            if (!r_w) begin
              r_t[14:8] <= {1'b0, reg_data_wr[5:0]};
            end else begin
              r_t[7:0] <= reg_data_wr;
              r_v      <= {r_t[14:8], reg_data_wr};
            end
            r_w <= ~r_w;
          end
          SEL_DATA:   r_v <= r_v + w_inc;
          SEL_OAMDMA: r_dma_page <= reg_data_wr;
          default: ;
        endcase
      end else if (w_rd) begin
        if (reg_sel == SEL_STATUS) r_w <= 1'b0;
        if (reg_sel == SEL_DATA)   r_v <= r_v + w_inc;
      end
    end
  end

  // Status flags and NMI. Clear beats set; a status read on the vblank_set
  // edge suppresses the set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank <= 1'b0;
      r_s0     <= 1'b0;
      r_ovf    <= 1'b0;
      r_nmi    <= 1'b0;
    end else begin
      if (vblank_clr) begin
        r_vblank <= 1'b0;
        r_s0     <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_status_rd)     r_vblank <= 1'b0;
        else if (vblank_set) r_vblank <= 1'b1;
        if (sprite0_hit_set) r_s0  <= 1'b1;
        if (overflow_set)    r_ovf <= 1'b1;
      end
      r_nmi <= r_vblank & r_ctrl[7];
    end
  end

  assign reg_data_rd = r_rd;
  assign ppuctrl     = r_ctrl;
  assign ppumask     = r_mask;
  assign vram_v      = r_v;
  assign vram_t      = r_t;
  assign fine_x      = r_x;
  assign vram_rd     = w_data_rd;
  assign vram_wr     = w_wr & (reg_sel == SEL_DATA);
  assign vram_addr   = r_v[13:0];
  assign vram_wdata  = vram_wr ? reg_data_wr : '0;
  assign oam_addr    = r_oam_addr;
  assign oam_we      = w_wr & (reg_sel == SEL_OAMDATA);
  assign oam_wdata   = oam_we ? reg_data_wr : '0;
  assign dma_start   = r_dma_start;
  assign dma_page    = r_dma_page;
  assign nmi         = r_nmi;

endmodule

// File: doc/ppu_reg_responder.md
Name: ppu_reg_responder

Overview:
PPU-side responder for the CPU→PPU register interface (reg_sel/reg_en/reg_rw/reg_data_wr/reg_data_rd). It decodes CPU accesses to PPUCTRL…PPUDATA and OAMDMA, and holds the control, mask and status state. It maintains the scroll/VRAM address registers (v, t, fine-x, write toggle w), sequences VRAM and OAM accesses for PPUDATA and OAMDATA, and generates NMI. It sits between the CPU memory map and the PPU render core, VRAM, OAM and the DMA engine.

Parameters:
PAL_HI, 6'h3F, v[13:8] value that marks a palette PPUDATA access.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
clock_en  input  1  CPU-cycle enable; never asserted on two consecutive clocks
reg_sel  input  reg_t  register select (PPUCTRL..PPUDATA, OAMDMA)
reg_en  input  1  access valid
reg_rw  input  1  1=write, 0=read
reg_data_wr  input  8  CPU write data
reg_data_rd  output  8  read data, registered
vblank_set  input  1  1-clock pulse from PPU timing, start of vblank
vblank_clr  input  1  1-clock pulse, pre-render line; clears vblank, sprite0_hit, overflow
sprite0_hit_set  input  1  pulse; sets status bit 6
overflow_set  input  1  pulse; sets status bit 5
ppuctrl  output  8  current PPUCTRL
ppumask  output  8  current PPUMASK
vram_v  output  15  current VRAM address v
vram_t  output  15  temporary address t
fine_x  output  3  fine X scroll
vram_rd  output  1  1-clock VRAM read strobe
vram_wr  output  1  1-clock VRAM write strobe
vram_addr  output  14  VRAM address, = v[13:0] at strobe
vram_wdata  output  8  VRAM write data
vram_rdata  input  8  VRAM read data, valid 1 clock after vram_rd
oam_addr  output  8  OAMADDR
oam_we  output  1  OAM write strobe
oam_wdata  output  8  OAM write data
oam_rdata  input  8  OAM data at oam_addr, combinational
dma_start  output  1  1-clock pulse on OAMDMA write
dma_page  output  8  page written to OAMDMA
nmi  output  1  NMI request, level

Behaviour:
- An access is accepted on a clock edge with reg_en & clock_en. All register side effects occur only on accepted edges.
- Reset: every output and internal register is 0, including v, t, x, w, status bits, the read buffer and the latch. FSM goes to IDLE. An access in flight is abandoned.
- reg_data_rd is loaded on the accepting edge of a read and holds until the next read. The CPU samples it in the following clock_en cycle.
- Open-bus latch: every accepted write stores reg_data_wr. Reads return latch bits where a register has no bits.
- PPUCTRL write: ctrl<=d; t[11:10]<=d[1:0].
- PPUMASK write: mask<=d.
- PPUSTATUS read: returns {vblank, s0hit, ovf, latch[4:0]}; then vblank<=0, w<=0.
- OAMADDR write: oam_addr<=d.
- OAMDATA write: oam_we=1 for one clock with oam_wdata=d; oam_addr+=1, wrapping at 8 bits. Read returns oam_rdata with no increment.
- PPUSCROLL write:
  - w=0: t[4:0]<=d[7:3], x<=d[2:0], w<=1.
  - w=1: t[14:12]<=d[2:0], t[9:5]<=d[7:3], w<=0.
- PPUADDR write:
  - w=0: t[13:8]<=d[5:0], t[14]<=0, w<=1.
  - w=1: t[7:0]<=d, v<=new t, w<=0.
- PPUDATA write: vram_wr for one clock, vram_addr=v, vram_wdata=d. Then v+=(ctrl[2]?32:1), mod 2^15.
- PPUDATA read FSM (IDLE→RD_WAIT→IDLE):
  - Accepting edge: vram_rd=1 at v; non-palette reads load reg_data_rd<=read buffer; v increments as for a write; state goes to RD_WAIT.
  - RD_WAIT edge: buffer<=vram_rdata. Palette reads (v[13:8]==PAL_HI at access) instead load reg_data_rd<={latch[7:6], vram_rdata[5:0]}, and the buffer also takes vram_rdata.
  - Any access during RD_WAIT is accepted normally; the buffer update still completes.
- Reads of write-only registers (CTRL, MASK, OAMADDR, SCROLL, ADDR) and of OAMDMA return the latch.
- OAMDMA write: dma_page<=d; dma_start=1 for one clock.
- Status flags:
  - vblank_set sets vblank; vblank_clr clears vblank, s0hit and ovf; set pulses set bits 6 and 5.
  - vblank_clr wins over any simultaneous set.
  - A PPUSTATUS read on the same edge as vblank_set returns vblank=0 and vblank stays 0 (suppressed).
- nmi = vblank & ctrl[7], registered one clock. A CTRL write 0→1 on bit 7 while vblank=1 raises nmi.

Test Plan:
- Reset mid-write, after the first PPUADDR write (w=1) → all outputs 0, w=0; next PPUADDR writes $21,$08 → v=$2108.
- ctrl=$04, PPUADDR $20/$00, three PPUDATA writes → vram_wr at $2000, $2020, $2040; v=$2060. With v=$7FFF and ctrl=$00, a write → v wraps to $0000.
- v=$2000, VRAM[$2000]=$AA, [$2001]=$BB, buffer=$00: two PPUDATA reads → returns $00 then $AA; buffer=$BB. v=$3F01 with VRAM=$2D, latch=$C0 → returns $ED.
- PPUSCROLL $7D then $5E → x=5, t[4:0]=$0F, t[14:12]=6, t[9:5]=$0B, w=0. A PPUSTATUS read between the two writes resets w.
- vblank_set with ctrl[7]=1 → nmi=1; PPUSTATUS read returns bit7=1 and nmi drops. A read coincident with vblank_set → bit7=0, no nmi.
- OAMADDR $FF, OAMDATA write $12 → oam_we at $FF, oam_addr=$00. OAMDMA write $02 → dma_start pulse, dma_page=$02.
